ddr_frac_clock_divider: RTL
===========================

// Module: ddr_frac_clock_divider
// PURPOSE
//  Programmable clock divider: divides the PLL master clock by one of two runtime divisors (A/B).
//  Divisor switches glitch-free, only at period boundaries. Phase offset has half-cycle resolution.
//  Emits a rise/fall bit pair per master cycle for a DDR output IO register, so odd divisors can
//  have exactly 50% duty. Generalises the fixed 7/8 APU/CPU clock generators; one instance per console clock.
// PARAMETERS
//  W   4   divisor width; legal divisor range 2..2^W-1; phase and counter are W+1 bits
// PORTS
//  clock_in      in   1    master clock (PLL global)
//  reset         in   1    synchronous, active-low
//  enable        in   1    1 = run; 0 = freeze counter and outputs (stretches current level)
//  div_a         in   W    divisor A, in master cycles
//  div_b         in   W    divisor B, in master cycles
//  sel_b         in   1    divisor select for next period (1 = B), sampled only at wrap
//  phase         in   W+1  start offset in half master cycles, loaded on reset/resync
//  resync        in   1    restart pulse; reloads phase and divisor, keeps div_err
//  dout_rise     out  1    level for first half of master cycle (to DDR D_OUT_0)
//  dout_fall     out  1    level for second half of master cycle (to DDR D_OUT_1)
//  period_start  out  1    1-cycle pulse, aligned with the first output pair of each period
//  cur_div       out  W    divisor of the period currently being output
//  div_err       out  1    sticky: illegal divisor or phase was loaded
// BEHAVIOUR
//  - State: half-cycle counter h[W:0] and D = cur_div. Output period = 2*D half-cycles.
//    Low half comes first, then high: half-cycle index x is high iff x >= D.
//  - Divisor load value Dn = (sel_b ? div_b : div_a). If Dn < 2: load 2 and set div_err.
//  - reset low, at each edge: h <= phase; D <= Dn; dout_rise, dout_fall, period_start <= 0; div_err <= 0.
//    If phase >= 2*Dn: h <= 0 and div_err <= 1.
//  - resync high with reset high: same loads as reset, except div_err is only set, never cleared.
//    resync takes priority over enable=0 and over wrap.
//  - Run edge (reset=1, resync=0, enable=1):
//    - dout_rise    <= (h >= D)
//    - dout_fall    <= (((h+1) mod 2D) >= D)
//    - period_start <= (h < 2)
//    - s = h + 2
//    - if s >= 2*D: h <= s - 2*D (wrap; leftover 0 or 1); D <= Dn (clamped, div_err rule applies)
//    - else: h <= s
//  - Outputs are registered and lag h by one edge. The first valid pair appears one edge after
//    reset/resync release and corresponds to h = phase.
//  - enable=0: h, D, dout_*, cur_div hold; period_start <= 0.
//  - sel_b/div_a/div_b changes mid-period have no effect until the next wrap; a divisor change
//    never produces a runt pulse.
//  - Arithmetic is unsigned, W+2 bits internally, so 2*D and s do not overflow at D = 2^W-1.
// CONFIGURATION
//  CLKDIV_DDR_EN defined: behaviour as above (half-cycle resolution for duty and phase).
//  CLKDIV_DDR_EN undefined (SDR):
//    - dout_fall is driven equal to dout_rise.
//    - phase[0] is ignored (treated as 0), so h is always even.
//    - Odd D has high time floor(D/2) cycles.
//  Counter, wrap, period_start and div_err are identical in both modes.
// TESTING (pairs listed as rise,fall per cycle after the first valid edge)
//  1. div_a=8, sel_b=0, phase=0
//     -> 00,00,00,00,11,11,11,11 repeating; period_start on every 8th cycle, on the first 00.
//  2. div_a=7, phase=0
//     -> DDR: 00,00,00,01,11,11,11
//     -> SDR: 00,00,00,00,11,11,11
//     -> period 7 cycles in both modes.
//  3. div_a=8, phase=1, DDR
//     -> 00,00,00,01,11,11,11,10 repeating; period_start when h wraps to 1.
//  4. div_a=8, div_b=7; sel_b raised at cycle 3 of a period
//     -> that period completes as 8; next period 7 (00,00,00,01,11,11,11);
//        cur_div changes 8->7 on the output edge carrying that period's period_start.
//  5. div_a=1
//     -> clamped to D=2, div_err=1, pattern 00,11;
//        then div_a=5 with resync -> div_err stays 1; only reset clears it.
//  6. reset low for 1 cycle mid high-phase
//     -> outputs 0 next edge; restart from phase one edge after release.
//     enable=0 for 3 cycles
//     -> pair and cur_div frozen; period stretched by exactly 3 cycles.

Source files
------------

// File: rtl/ddr_frac_clock_divider_if.sv
// Control and DDR output bundle for ddr_frac_clock_divider.
// The master side configures and restarts the divider; the slave side is the divider itself.
interface ddr_frac_clock_divider_if #(
  parameter int W = 4
);
  logic         enable;
  logic [W-1:0] div_a;
  logic [W-1:0] div_b;
  logic         sel_b;
  logic [W:0]   phase;
  logic         resync;
  logic         dout_rise;
  logic         dout_fall;
  logic         period_start;
  logic [W-1:0] cur_div;
  logic         div_err;

  modport master (
    output enable, div_a, div_b, sel_b, phase, resync,
    input  dout_rise, dout_fall, period_start, cur_div, div_err
  );

  modport slave (
    input  enable, div_a, div_b, sel_b, phase, resync,
    output dout_rise, dout_fall, period_start, cur_div, div_err
  );
endinterface

// File: rtl/ddr_frac_clock_divider.sv
// Two-divisor clock divider producing rise/fall pairs for a DDR output register.
// Define CLKDIV_DDR_EN for half-cycle duty/phase; otherwise SDR (dout_fall == dout_rise, phase[0] ignored).
module ddr_frac_clock_divider #(
  parameter int W = 4
) (
  input logic                    clock_in,
  input logic                    reset,
  ddr_frac_clock_divider_if.slave bus
);
  localparam int CW = W + 2;

  logic [W:0]    h_q, h_d;
  logic [W-1:0]  div_q, div_d;
  logic [W-1:0]  cur_div_q, cur_div_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          ps_q, ps_d;
  logic          err_q, err_d;

  logic [W-1:0]  dn_raw, dn;
  logic          dn_bad, ph_bad;
  logic [CW-1:0] ph_eff, two_dn, h_ext, d_ext, two_d, s;
  logic [W:0]    h_load;
`ifdef CLKDIV_DDR_EN
  logic [CW-1:0] h1, h1_mod;
`endif

  always_comb begin
    dn_raw = bus.sel_b ? bus.div_b : bus.div_a;
    dn_bad = dn_raw < W'(2);
    dn     = dn_bad ? W'(2) : dn_raw;
    ph_eff = CW'(bus.phase);
`ifndef CLKDIV_DDR_EN
    ph_eff[0] = 1'b0;
`endif
    two_dn = CW'(dn) << 1;
    ph_bad = ph_eff >= two_dn;
    h_load = ph_bad ? '0 : ph_eff[W:0];

    h_ext = CW'(h_q);
    d_ext = CW'(div_q);
    two_d = d_ext << 1;
    s     = h_ext + CW'(2);
`ifdef CLKDIV_DDR_EN
    // Second half of the master cycle is the next half-cycle index, modulo the period.
    h1     = h_ext + CW'(1);
    h1_mod = (h1 >= two_d) ? h1 - two_d : h1;
`endif

    h_d       = h_q;
    div_d     = div_q;
    cur_div_d = cur_div_q;
    rise_d    = rise_q;
    fall_d    = fall_q;
    ps_d      = 1'b0;
    err_d     = err_q;

    if (!reset || bus.resync) begin
      h_d       = h_load;
      div_d     = dn;
      cur_div_d = dn;
      rise_d    = 1'b0;
      fall_d    = 1'b0;
      err_d     = (reset ? err_q : 1'b0) | dn_bad | ph_bad;
    end else if (bus.enable) begin
      rise_d = h_ext >= d_ext;
`ifdef CLKDIV_DDR_EN
      fall_d = h1_mod >= d_ext;
`else
      fall_d = h_ext >= d_ext;
`endif
      ps_d      = h_ext < CW'(2);
      cur_div_d = div_q;
      // Divisor only changes at the wrap, so a period is never cut short.
      if (s >= two_d) begin
        h_d   = h_q + (W+1)'(2) - {div_q, 1'b0};
        div_d = dn;
        err_d = err_q | dn_bad;
      end else begin
        h_d = h_q + (W+1)'(2);
      end
    end
  end

  always_ff @(posedge clock_in) begin
    h_q       <= h_d;
    div_q     <= div_d;
    cur_div_q <= cur_div_d;
    rise_q    <= rise_d;
    fall_q    <= fall_d;
    ps_q      <= ps_d;
    err_q     <= err_d;
  end

  assign bus.dout_rise    = rise_q;
  assign bus.dout_fall    = fall_q;
  assign bus.period_start = ps_q;
  assign bus.cur_div      = cur_div_q;
  assign bus.div_err      = err_q;
endmodule
